// File: rtl/rf_mp.sv
`default_nettype none
// ============================================================================
// Module   : rf_mp
// Purpose  : Parametrised multi-port register file with a per-entry pending
//            scoreboard, a sequenced whole-file clear engine and optional
//            write-to-read bypass.
// Options  : define RF_BYPASS_EN to forward the write port to the read ports
//            in the write cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rf_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_pend,
    output logic            rs2_pend,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_addr,
    input  logic            clr_req,
    output logic            busy
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam logic [AW-1:0] c_LAST_IDX = AW'(NREGS - 1);
    localparam bit            c_HAS_ZERO = (ZERO_REG != 0);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_idx;
    logic [AW-1:0]   w_idx_nxt;
    logic [XLEN-1:0] r_mem [NREGS];
    logic [NREGS-1:0] r_pend;

    logic            w_busy;
    logic            w_wr_ok;
    logic            w_iss_ok;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;
    logic            w_rs1_pend;
    logic            w_rs2_pend;

    // busy comes straight from the state register so it has no input path
    assign w_busy = (r_state == S_CLEAR);
    assign busy   = w_busy;

    // Writes and issue marks are frozen while the clear engine owns the file;
    // entry 0 silently discards both when it is hardwired.
    assign w_wr_ok  = wr_en  && !w_busy && !(c_HAS_ZERO && (wr_addr  == '0));
    assign w_iss_ok = iss_en && !w_busy && !(c_HAS_ZERO && (iss_addr == '0));

    // Clear FSM state and walking index register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Clear FSM next state: one entry per cycle, leave after the last one
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = S_CLEAR;
                    w_idx_nxt   = '0;
                end
            end
            S_CLEAR: begin
                w_idx_nxt = r_idx + AW'(1);
                if (r_idx == c_LAST_IDX) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Storage array: clear engine has priority, otherwise the write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_busy) begin
            r_mem[r_idx] <= '0;
        end else if (w_wr_ok) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Pending scoreboard: issue set beats writeback clear on the same entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_busy) begin
                    if (r_idx == AW'(i)) begin
                        r_pend[i] <= 1'b0;
                    end
                end else if (w_iss_ok && (iss_addr == AW'(i))) begin
                    r_pend[i] <= 1'b1;
                end else if (w_wr_ok && (wr_addr == AW'(i))) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    // Read port 1: array lookup, optional forward, entry-0 override last
    always_comb begin
        w_rs1_data = r_mem[rs1_addr];
        w_rs1_pend = r_pend[rs1_addr];
`ifdef RF_BYPASS_EN
        if (w_wr_ok && (rs1_addr == wr_addr)) begin
            w_rs1_data = wr_data;
            w_rs1_pend = w_iss_ok && (iss_addr == rs1_addr);
        end
`else
`endif
        if (c_HAS_ZERO && (rs1_addr == '0)) begin
            w_rs1_data = '0;
            w_rs1_pend = 1'b0;
        end
    end

    // Read port 2: same structure as port 1
    always_comb begin
        w_rs2_data = r_mem[rs2_addr];
        w_rs2_pend = r_pend[rs2_addr];
`ifdef RF_BYPASS_EN
        if (w_wr_ok && (rs2_addr == wr_addr)) begin
            w_rs2_data = wr_data;
            w_rs2_pend = w_iss_ok && (iss_addr == rs2_addr);
        end
`else
`endif
        if (c_HAS_ZERO && (rs2_addr == '0)) begin
            w_rs2_data = '0;
            w_rs2_pend = 1'b0;
        end
    end

    assign rs1_data = w_rs1_data;
    assign rs2_data = w_rs2_data;
    assign rs1_pend = w_rs1_pend;
    assign rs2_pend = w_rs2_pend;

endmodule
`default_nettype wire

// File: tb/tb_rf_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_mp
// Purpose  : Self-checking bench for rf_mp: directed vector table, multi-cycle
//            clear/reset sequences, randomized traffic against a reference
//            model, and a 64-bit / 16-entry / no-x0 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int B_NREGS = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   rs1_addr, rs2_addr, wr_addr, iss_addr;
    logic [XLEN-1:0] rs1_data, rs2_data, wr_data;
    logic            rs1_pend, rs2_pend, wr_en, iss_en, clr_req, busy;

    logic [3:0]      b_rs1_addr, b_rs2_addr, b_wr_addr, b_iss_addr;
    logic [63:0]     b_rs1_data, b_rs2_data, b_wr_data;
    logic            b_rs1_pend, b_rs2_pend, b_wr_en, b_iss_en, b_clr_req, b_busy;

    rf_mp #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_pend(rs1_pend), .rs2_pend(rs2_pend),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr),
        .clr_req(clr_req), .busy(busy)
    );

    rf_mp #(.XLEN(64), .NREGS(B_NREGS), .ZERO_REG(0)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr(b_rs1_addr), .rs2_addr(b_rs2_addr),
        .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
        .rs1_pend(b_rs1_pend), .rs2_pend(b_rs2_pend),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .iss_en(b_iss_en), .iss_addr(b_iss_addr),
        .clr_req(b_clr_req), .busy(b_busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model (architectural view) ----------------
    logic [XLEN-1:0] m_mem  [NREGS];
    bit              m_pend [NREGS];
    int              m_left;   // clear cycles still to run
    int              m_idx;    // next entry the clear will zero

    function automatic bit m_busy();
        return m_left > 0;
    endfunction

    function automatic bit m_wr_acc();
        return wr_en && !m_busy() && (wr_addr != 0);
    endfunction

    function automatic bit m_iss_acc();
        return iss_en && !m_busy() && (iss_addr != 0);
    endfunction

    function automatic logic [XLEN-1:0] m_rd(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef RF_BYPASS_EN
        if (m_wr_acc() && (a == wr_addr)) return wr_data;
`endif
        return m_mem[a];
    endfunction

    function automatic logic m_pd(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
        if (m_wr_acc() && (a == wr_addr)) return m_iss_acc() && (iss_addr == a);
`endif
        return m_pend[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
        m_left = 0;
        m_idx  = 0;
    endtask

    task automatic model_step();
        if (m_busy()) begin
            m_mem[m_idx]  = '0;
            m_pend[m_idx] = 1'b0;
            m_idx++;
            m_left--;
        end else begin
            bit wa, ia;
            wa = m_wr_acc();
            ia = m_iss_acc();
            if (wa) begin
                m_mem[wr_addr]  = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (ia) m_pend[iss_addr] = 1'b1;
            if (clr_req) begin
                m_left = NREGS;
                m_idx  = 0;
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("m_rs1_data", 64'(rs1_data), 64'(m_rd(rs1_addr)));
        chk("m_rs2_data", 64'(rs2_data), 64'(m_rd(rs2_addr)));
        chk("m_rs1_pend", 64'(rs1_pend), 64'(m_pd(rs1_addr)));
        chk("m_rs2_pend", 64'(rs2_pend), 64'(m_pd(rs2_addr)));
        chk("m_busy",     64'(busy),     64'(m_busy()));
    endtask

    // one clock: compare at negedge, advance model with the sampled inputs
    task automatic cycle();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; iss_en = 1'b0; clr_req = 1'b0;
    endtask

    task automatic fill_all();
        for (int i = 1; i < NREGS; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = 32'h100 + 32'(i);
            rs1_addr = AW'(i); rs2_addr = AW'(i - 1);
            cycle();
        end
        idle();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic            we;
        logic [AW-1:0]   wa;
        logic [XLEN-1:0] wd;
        logic            ie;
        logic [AW-1:0]   ia;
        logic [AW-1:0]   r1, r2;
        logic [XLEN-1:0] d1, d2;
        logic            p1, p2;
    } vec_t;

    vec_t tbl [8];
    int   cnt;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{1'b1, 5'd5,  32'h12345678, 1'b0, 5'd0,  5'd5,  5'd0,  32'h12345678, 32'h0,        1'b0, 1'b0};
        tbl[1] = '{1'b1, 5'd0,  32'hDEADBEEF, 1'b0, 5'd0,  5'd0,  5'd5,  32'h0,        32'h12345678, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd7,  5'd5,  32'h0,        32'h12345678, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 5'd7,  32'hCAFE0007, 1'b0, 5'd0,  5'd7,  5'd7,  32'hCAFE0007, 32'hCAFE0007, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 5'd7,  32'h00000077, 1'b1, 5'd7,  5'd7,  5'd0,  32'h00000077, 32'h0,        1'b1, 1'b0};
        tbl[5] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  5'd7,  32'h0,        32'h00000077, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd30, 5'd31, 5'd30, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b1};
        tbl[7] = '{1'b1, 5'd30, 32'h0000001E, 1'b0, 5'd0,  5'd30, 5'd31, 32'h0000001E, 32'hFFFFFFFF, 1'b0, 1'b0};

        rst_n = 1'b0;
        idle();
        wr_addr = '0; wr_data = '0; iss_addr = '0; rs1_addr = '0; rs2_addr = '0;
        b_wr_en = 1'b0; b_iss_en = 1'b0; b_clr_req = 1'b0;
        b_wr_addr = '0; b_wr_data = '0; b_iss_addr = '0; b_rs1_addr = '0; b_rs2_addr = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state: every entry 0, no pending, not busy
        for (int i = 0; i < NREGS; i++) begin
            rs1_addr = AW'(i); rs2_addr = AW'(NREGS - 1 - i);
            #1;
            chk("rst_data", 64'(rs1_data), 64'h0);
            chk("rst_pend1", 64'(rs1_pend), 64'h0);
            chk("rst_pend2", 64'(rs2_pend), 64'h0);
        end
        chk("rst_busy", 64'(busy), 64'h0);
        @(posedge clk); #1;

        // x0 ignores writes
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF; rs1_addr = 5'd0;
        cycle();
        idle(); #1;
        chk("x0_write", 64'(rs1_data), 64'h0);

        // write with read of same address in the same cycle
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h12345678; rs1_addr = 5'd5;
        #1;
`ifdef RF_BYPASS_EN
        chk("byp_same_cycle", 64'(rs1_data), 64'h12345678);
`else
        chk("byp_same_cycle", 64'(rs1_data), 64'h0);
`endif
        cycle();
        idle(); #1;
        chk("wr_next_cycle", 64'(rs1_data), 64'h12345678);
        cycle();

        // directed table: apply one cycle, then inspect the resulting state
        for (int k = 0; k < 8; k++) begin
            wr_en = tbl[k].we; wr_addr = tbl[k].wa; wr_data = tbl[k].wd;
            iss_en = tbl[k].ie; iss_addr = tbl[k].ia;
            rs1_addr = tbl[k].r1; rs2_addr = tbl[k].r2;
            cycle();
            idle(); #1;
            chk("tbl_d1", 64'(rs1_data), 64'(tbl[k].d1));
            chk("tbl_d2", 64'(rs2_data), 64'(tbl[k].d2));
            chk("tbl_p1", 64'(rs1_pend), 64'(tbl[k].p1));
            chk("tbl_p2", 64'(rs2_pend), 64'(tbl[k].p2));
            cycle();
        end

        // clear sequence with a blocked write and a repeated clr_req
        fill_all();
        iss_en = 1'b1; iss_addr = 5'd9;  cycle();
        iss_addr = 5'd20; cycle();
        idle();
        clr_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h55;
        cycle();
        idle();
        chk("clr_start", 64'(busy), 64'h1);
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            idle();
            if (cnt == 5) begin
                wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hAA;
                clr_req = 1'b1; iss_en = 1'b1; iss_addr = 5'd4;
            end
            rs1_addr = AW'(cnt); rs2_addr = AW'(NREGS - 1 - cnt);
            cycle();
            cnt++;
        end
        idle();
        chk("clr_len", 64'(cnt), 64'(NREGS));
        for (int i = 0; i < NREGS; i++) begin
            rs1_addr = AW'(i); rs2_addr = AW'(i);
            #1;
            chk("clr_data", 64'(rs1_data), 64'h0);
            chk("clr_pend", 64'(rs2_pend), 64'h0);
        end
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        cycle();
        idle(); rs1_addr = 5'd3; #1;
        chk("post_clr_wr", 64'(rs1_data), 64'h33);
        cycle();

        // reset in the middle of a clear
        fill_all();
        clr_req = 1'b1; cycle(); idle();
        cnt = 0;
        while (busy === 1'b1 && cnt < 10) begin
            cycle();
            cnt++;
        end
        chk("mid_busy_before", 64'(busy), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_busy_drop", 64'(busy), 64'h0);
        model_reset();
        for (int i = 0; i < NREGS; i++) begin
            rs1_addr = AW'(i); #1;
            chk("mid_rst_data", 64'(rs1_data), 64'h0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        cycle(); cycle();
        chk("mid_idle", 64'(busy), 64'h0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            wr_en    = ($urandom_range(0, 1) == 1);
            wr_addr  = AW'($urandom_range(0, NREGS - 1));
            wr_data  = $urandom;
            iss_en   = ($urandom_range(0, 2) == 0);
            iss_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, NREGS - 1));
            rs1_addr = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, NREGS - 1));
            rs2_addr = ($urandom_range(0, 3) == 0) ? iss_addr : AW'($urandom_range(0, NREGS - 1));
            clr_req  = ($urandom_range(0, 149) == 0);
            cycle();
        end
        idle();

        // 64-bit, 16-entry instance with a writable x0
        b_wr_en = 1'b1; b_wr_addr = 4'd0;  b_wr_data = 64'hFFFF_FFFF_FFFF_FFFF; cycle();
        b_wr_addr = 4'd15; cycle();
        b_wr_en = 1'b0; b_rs1_addr = 4'd0; b_rs2_addr = 4'd15; #1;
        chk("w64_x0",  b_rs1_data, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("w64_x15", b_rs2_data, 64'hFFFF_FFFF_FFFF_FFFF);
        b_clr_req = 1'b1; cycle(); b_clr_req = 1'b0;
        cnt = 0;
        while (b_busy === 1'b1 && cnt < 200) begin
            cycle();
            cnt++;
        end
        chk("w64_clr_len", 64'(cnt), 64'(B_NREGS));
        #1;
        chk("w64_clr_x0",  b_rs1_data, 64'h0);
        chk("w64_clr_x15", b_rs2_data, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_mp.md
# rf_mp

Parametrised register file for the RISC-V core, the next generation of the 32x32 file. Width and depth are configurable, and x0 hardwiring is optional. It adds a per-register pending scoreboard for hazard detection, a sequenced clear engine, and optional write-to-read bypass. It sits between decode (read ports, issue marking) and writeback (write port).

## Interface
- XLEN, 32, register width in bits
- NREGS, 32, number of registers; must be a power of two and at least 2
- AW, $clog2(NREGS), address width (derived; do not override)
- ZERO_REG, 1, when 1 entry 0 always reads 0 and ignores writes and issue marks

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- rs1_addr  in  AW  read address, port 1
- rs2_addr  in  AW  read address, port 2
- rs1_data  out  XLEN  read data, port 1 (combinational)
- rs2_data  out  XLEN  read data, port 2 (combinational)
- rs1_pend  out  1  register at rs1_addr has an outstanding write
- rs2_pend  out  1  register at rs2_addr has an outstanding write
- wr_en  in  1  write enable
- wr_addr  in  AW  write address
- wr_data  in  XLEN  write data
- iss_en  in  1  mark iss_addr pending (instruction issued with this destination)
- iss_addr  in  AW  destination being issued
- clr_req  in  1  single-cycle pulse requesting a clear of the whole file
- busy  out  1  clear engine active; wr_en and iss_en are ignored while high

## Operation
- **Reset:** while rst_n is low, all entries, all pending bits and the clear index are 0, the FSM is in IDLE, and busy is 0.
- **Read:** rsN_data = reg[rsN_addr]. It is forced to 0 when ZERO_REG=1 and rsN_addr==0.
- **Write:** reg[wr_addr] <= wr_data on the edge when wr_en=1 and busy=0.
  - Dropped when ZERO_REG=1 and wr_addr==0.
- **Scoreboard, base rules:**
  - iss_en=1 with busy=0 sets pend[iss_addr]; never set for entry 0 when ZERO_REG=1.
  - An accepted write clears pend[wr_addr].
  - A write to an entry whose pending bit is clear still updates the entry.
- **Scoreboard, same-address conflict:** when iss_en and wr_en target the same address in one cycle, the entry is written and its pending bit ends set (set wins).
- **rsN_pend:** equals pend[rsN_addr], with the bypass qualification described under Configuration.
- **Clear FSM states:** IDLE and CLEAR.
  - IDLE -> CLEAR when clr_req=1; idx <= 0.
  - In CLEAR, each cycle writes reg[idx] <= 0, clears pend[idx], and increments idx.
  - CLEAR -> IDLE on the edge that clears idx == NREGS-1.
  - busy = (state == CLEAR), taken directly from the state register.
  - clr_req while in CLEAR is ignored and does not restart the sequence.
  - Reads during CLEAR return current contents: entries already cleared read 0, the rest read their old values.
- **Reset mid-clear:** the clear aborts immediately. The result is the reset state: FSM in IDLE, all entries 0.

## Timing
- **Write:** takes effect on the next edge. Without bypass, a read of the same address shows the new value one cycle after wr_en.
- **Issue:** the pending bit is visible on rsN_pend the cycle after iss_en.
- **Clear start:** busy rises the cycle after clr_req is sampled.
- **Clear duration:** busy stays high for exactly NREGS cycles.
- **Clear end:** the first accepted write or issue is in the cycle after busy falls.
- A wr_en or iss_en presented in the same cycle as clr_req, while still in IDLE, is accepted.
- Read paths are purely combinational from address to data, with no sequential stage.

## Configuration
- **RF_BYPASS_EN defined:**
  - When wr_en=1, busy=0, a write is allowed, and rsN_addr==wr_addr, rsN_data = wr_data in the same cycle.
  - In that case rsN_pend = 0 unless iss_en also targets the same address.
- **RF_BYPASS_EN undefined:**
  - rsN_data shows the old contents during the write cycle.
  - rsN_pend stays at the stored pending value until the edge.

## Test plan
- **Reset and x0:**
  - Stimulus: reset, then read all addresses; write 0xDEADBEEF to x0.
  - Required response: every read returns 0, busy=0, all pend=0; x0 still reads 0.
- **Write/read and bypass:**
  - Stimulus: write 0x12345678 to x5 with rs1_addr=5 in the same cycle.
  - Required response with RF_BYPASS_EN: rs1_data = 0x12345678 that cycle.
  - Required response without it: rs1_data = 0 that cycle, then 0x12345678 the next cycle.
- **Scoreboard:**
  - Stimulus: iss x7, then read rs2_addr=7; later write x7.
  - Required response: rs2_pend=1 the cycle after issue; rs2_pend=0 after the write.
  - Stimulus: iss x7 and write x7 in the same cycle.
  - Required response: pend stays 1 and x7 holds the written data.
- **Clear sequence:**
  - Stimulus: fill all registers with their index + 0x100, then pulse clr_req.
  - Required response: busy high for exactly NREGS cycles.
  - Required response: wr_en x3=0xAA during busy is ignored.
  - Required response: all entries read 0 and all pend=0 after busy falls.
- **Reset mid-clear:**
  - Stimulus: assert rst_n=0 at clear cycle 10.
  - Required response: busy drops immediately, FSM is in IDLE, all entries read 0.
  - Stimulus: a clr_req during CLEAR.
  - Required response: busy duration is unchanged.
- **Parametrisation:**
  - Stimulus: XLEN=64, NREGS=16, ZERO_REG=0; write 0xFFFF_FFFF_FFFF_FFFF to x0 and x15.
  - Required response: both read back that value; the clear takes 16 cycles.
